// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD accumulator: FSM states, digit limits
// and active-low seven-segment encodings (bit0 = a ... bit6 = g).
package bcd_pkg;

  localparam int unsigned DEFAULT_DIGITS = 3;
  localparam logic [3:0]  BCD_MAX        = 4'd9;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADD    = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  // Non-BCD codes blank the digit; they never reach the committed total.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder with carry in/out; reused serially across the accumulator digits.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] raw;

  always_comb begin
    raw  = 5'(a) + 5'(b) + 5'(cin);
    s    = raw[3:0];
    cout = 1'b0;
    if (raw > {1'b0, BCD_MAX}) begin
      s    = 4'(raw + 5'd6);
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_accumulator.sv
// Running BCD total: each Add key press adds a single BCD digit using a
// digit-serial add, then commits the result and drives seven-segment outputs.
module bcd_accumulator
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = DEFAULT_DIGITS
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Add,
  input  logic [3:0]            Din,
  output logic                  Busy,
  output logic                  Err,
  output logic                  Ovf,
  output logic [4*DIGITS-1:0]   Total,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t                  state;
  logic                    add_q;
  logic [3:0]              operand;
  logic [DIGITS-1:0][3:0]  work;
  logic                    carry;
  logic [IW-1:0]           idx;

  logic                    start;
  logic [3:0]              addend;
  logic [3:0]              sum;
  logic                    cout;

  assign start  = Add & ~add_q;
  assign addend = (idx == '0) ? operand : 4'd0;

  bcd_digit_add u_digit_add (
    .a    (work[idx]),
    .b    (addend),
    .cin  (carry),
    .s    (sum),
    .cout (cout)
  );

  // add_q resets high so a key held through reset release is not a press.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= S_IDLE;
      add_q   <= 1'b1;
      operand <= 4'd0;
      work    <= '0;
      carry   <= 1'b0;
      idx     <= '0;
      Total   <= '0;
      Busy    <= 1'b0;
      Err     <= 1'b0;
      Ovf     <= 1'b0;
    end else begin
      add_q <= Add;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (Din > BCD_MAX) begin
              Err <= 1'b1;
            end else begin
              operand <= Din;
              work    <= Total;
              carry   <= 1'b0;
              idx     <= '0;
              Busy    <= 1'b1;
              state   <= S_ADD;
            end
          end
        end
        S_ADD: begin
          work[idx] <= sum;
          carry     <= cout;
          if (idx == IW'(DIGITS - 1)) begin
            state <= S_COMMIT;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        S_COMMIT: begin
          Total <= work;
          if (carry) Ovf <= 1'b1;
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_seg
    assign HEX[7*i +: 7] = seg_decode(Total[4*i +: 4]);
  end

endmodule

// File: tb/tb_bcd_accumulator.sv
// Self-checking bench for bcd_accumulator: vector table, directed corner cases,
// and random presses compared against an integer-arithmetic reference model.
module tb_bcd_accumulator;

  localparam int unsigned D   = 3;
  localparam int          MOD = 1000;

  logic             clk = 1'b0;
  logic             rst;
  logic             add;
  logic [3:0]       din;
  logic             busy, err, ovf;
  logic [4*D-1:0]   total;
  logic [7*D-1:0]   hex;

  int n_pass  = 0;
  int n_total = 0;

  int m_tot;
  bit m_err, m_ovf;

  bcd_accumulator #(.DIGITS(D)) dut (
    .Clock (clk),
    .Reset (rst),
    .Add   (add),
    .Din   (din),
    .Busy  (busy),
    .Err   (err),
    .Ovf   (ovf),
    .Total (total),
    .HEX   (hex)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  din;
    logic [11:0] total;
    logic        ovf;
    logic        err;
    int          busy;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [6:0] seg_ref(input int d);
    logic [6:0] t [10];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return t[d];
  endfunction

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    int p = 1;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [7*D-1:0] to_hex(input int v);
    logic [7*D-1:0] r;
    int p = 1;
    for (int i = 0; i < D; i++) begin
      r[7*i +: 7] = seg_ref((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic void model_press(input int d);
    if (d > 9) m_err = 1'b1;
    else begin
      m_tot = m_tot + d;
      if (m_tot >= MOD) begin
        m_tot = m_tot - MOD;
        m_ovf = 1'b1;
      end
    end
  endfunction

  task automatic do_reset(input logic hold_add);
    @(negedge clk);
    rst = 1'b1; add = hold_add;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_tot = 0; m_err = 1'b0; m_ovf = 1'b0;
  endtask

  // One clean press; counts sampled cycles with Busy high (bounded wait).
  task automatic do_press(input logic [3:0] d, output int busy_cycles);
    @(negedge clk);
    din = d; add = 1'b1;
    @(negedge clk);
    add = 1'b0;
    busy_cycles = 0;
    repeat (D + 4) begin
      if (busy) busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic press_quiet(input logic [3:0] d);
    int bc;
    do_press(d, bc);
    model_press(int'(d));
  endtask

  task automatic check_state(input string tag);
    check({tag, " total"}, 64'(total), 64'(to_bcd(m_tot)));
    check({tag, " hex"},   64'(hex),   64'(to_hex(m_tot)));
    check({tag, " ovf"},   64'(ovf),   64'(m_ovf));
    check({tag, " err"},   64'(err),   64'(m_err));
  endtask

  initial begin
    int bc;
    logic [3:0] d;
    rst = 1'b1; add = 1'b0; din = 4'd0;

    vecs[0] = '{din: 4'd7,  total: 12'h007, ovf: 1'b0, err: 1'b0, busy: 4};
    vecs[1] = '{din: 4'd5,  total: 12'h012, ovf: 1'b0, err: 1'b0, busy: 4};
    vecs[2] = '{din: 4'd12, total: 12'h012, ovf: 1'b0, err: 1'b1, busy: 0};
    vecs[3] = '{din: 4'd9,  total: 12'h021, ovf: 1'b0, err: 1'b1, busy: 4};
    vecs[4] = '{din: 4'd0,  total: 12'h021, ovf: 1'b0, err: 1'b1, busy: 4};

    // Reset state
    do_reset(1'b0);
    @(negedge clk);
    check("reset total", 64'(total), 64'(0));
    check("reset hex",   64'(hex),   64'({D{7'b1000000}}));
    check("reset busy",  64'(busy),  64'(0));
    check("reset err",   64'(err),   64'(0));
    check("reset ovf",   64'(ovf),   64'(0));

    // Vector table
    for (int i = 0; i < 5; i++) begin
      do_press(vecs[i].din, bc);
      check($sformatf("vec%0d total", i), 64'(total), 64'(vecs[i].total));
      check($sformatf("vec%0d ovf", i),   64'(ovf),   64'(vecs[i].ovf));
      check($sformatf("vec%0d err", i),   64'(err),   64'(vecs[i].err));
      check($sformatf("vec%0d busy", i),  64'(bc),    64'(vecs[i].busy));
    end
    check("vec hex0 after 12", 64'(hex[6:0]), 64'(7'b1111001));
    check("vec hex1 after 12", 64'(hex[13:7]), 64'(7'b0100100));

    // 995 + 9 wraps to 004 with overflow
    do_reset(1'b0);
    for (int i = 0; i < 110; i++) press_quiet(4'd9);
    press_quiet(4'd5);
    check("preload 995", 64'(total), 64'(12'h995));
    check("preload ovf", 64'(ovf),   64'(0));
    press_quiet(4'd9);
    check("995+9 total", 64'(total), 64'(12'h004));
    check("995+9 ovf",   64'(ovf),   64'(1));
    check("995+9 hex",   64'(hex),   64'({7'b1000000, 7'b1000000, 7'b0011001}));

    // 999 + 1 ripples a carry through every digit
    do_reset(1'b0);
    for (int i = 0; i < 111; i++) press_quiet(4'd9);
    check("preload 999", 64'(total), 64'(12'h999));
    press_quiet(4'd1);
    check("999+1 total", 64'(total), 64'(12'h000));
    check("999+1 ovf",   64'(ovf),   64'(1));

    // Add held through reset release, then a second edge while busy
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    check("held add busy",  64'(busy),  64'(0));
    check("held add total", 64'(total), 64'(0));
    add = 1'b0;
    @(negedge clk);
    din = 4'd3; add = 1'b1;
    @(negedge clk); add = 1'b0;
    @(negedge clk); add = 1'b1;
    @(negedge clk); add = 1'b0;
    repeat (D + 4) @(negedge clk);
    check("dropped edge total", 64'(total), 64'(12'h003));
    check("dropped edge busy",  64'(busy),  64'(0));

    // Reset on the second ADD cycle discards the partial result
    do_reset(1'b0);
    press_quiet(4'd5);
    check("pre-abort total", 64'(total), 64'(12'h005));
    @(negedge clk);
    din = 4'd8; add = 1'b1;
    @(negedge clk); add = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("abort total", 64'(total), 64'(0));
    check("abort busy",  64'(busy),  64'(0));
    rst = 1'b0;
    repeat (D + 3) @(negedge clk);
    check("abort no commit total", 64'(total), 64'(0));
    check("abort no commit busy",  64'(busy),  64'(0));

    // Randomized presses against the reference model
    do_reset(1'b0);
    for (int i = 0; i < 60; i++) begin
      d = 4'($urandom_range(0, 11));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_press(d, bc);
      model_press(int'(d));
      check_state($sformatf("rnd%0d", i));
      check($sformatf("rnd%0d busy", i), 64'(bc), 64'((d > 4'd9) ? 0 : D + 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
